// File: rtl/bp_pkg.sv
// Shared branch-predictor types: default widths, queue depth and entry layout.
// The resolve queue counts statistics only when built with BRQ_STATS_EN.
package bp_pkg;

  localparam int PC_W_DEF      = 32;
  localparam int BRQ_DEPTH_DEF = 4;

  typedef struct packed {
    logic [PC_W_DEF-1:0] pc;
    logic                pred_taken;
  } brq_entry_t;

  function automatic logic brq_mispred(input logic pred, input logic actual);
    return pred ^ actual;
  endfunction

endpackage

// File: rtl/brq_fifo.sv
// Storage ring for the branch resolve queue: entry array plus head/tail
// pointers carrying an extra wrap bit so full and empty stay distinct.
module brq_fifo
  import bp_pkg::*;
#(
  parameter int DW    = PC_W_DEF + 1,
  parameter int DEPTH = BRQ_DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   head_q, head_d;
  logic [AW:0]   tail_q, tail_d;
  logic [AW:0]   diff;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (clr_i) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (pop_i)  head_d = head_q + 1'b1;
      if (push_i) tail_d = tail_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Data array needs no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push_i && !clr_i) mem_q[tail_q[AW-1:0]] <= wdata_i;
  end

  assign diff    = tail_q - head_q;
  assign rdata_o = mem_q[head_q[AW-1:0]];
  assign empty_o = (head_q == tail_q);
  assign full_o  = (head_q[AW-1:0] == tail_q[AW-1:0]) &&
                   (head_q[AW] != tail_q[AW]);
  assign count_o = CW'(diff);

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches feeding predictor training updates.
// Optional BRQ_STATS_EN adds saturating resolved/mispredict counters.
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int DEPTH = BRQ_DEPTH_DEF,
  parameter int CNT_W = 16,
  localparam int OW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pred_valid,
  input  logic [PC_W-1:0] pred_pc,
  input  logic            pred_taken,
  output logic            pred_ready,
  input  logic            res_valid,
  input  logic            res_taken,
  output logic            upd_valid,
  output logic [PC_W-1:0] upd_pc,
  output logic            upd_taken,
  output logic            mispredict,
  output logic            res_err,
`ifdef BRQ_STATS_EN
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count,
`endif
  output logic [OW-1:0]   occupancy
);

  localparam int DW = PC_W + 1;

  logic [DW-1:0]   head_e;
  logic            full, empty;
  logic            push, pop, mis;
  logic            upd_valid_q, upd_taken_q, mis_q, err_q;
  logic [PC_W-1:0] upd_pc_q;

  assign push = pred_valid && !full;
  assign pop  = res_valid && !empty;
  assign mis  = pop && brq_mispred(head_e[0], res_taken);

  // A mispredict clears the ring, dropping any same-edge wrong-path push.
  brq_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (mis),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({pred_pc, pred_taken}),
    .rdata_o (head_e),
    .full_o  (full),
    .empty_o (empty),
    .count_o (occupancy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_valid_q <= 1'b0;
      upd_pc_q    <= '0;
      upd_taken_q <= 1'b0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      upd_valid_q <= pop;
      mis_q       <= mis;
      err_q       <= res_valid && empty;
      if (pop) begin
        upd_pc_q    <= head_e[DW-1:1];
        upd_taken_q <= res_taken;
      end
    end
  end

`ifdef BRQ_STATS_EN
  logic [CNT_W-1:0] br_q, misc_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_q   <= '0;
      misc_q <= '0;
    end else begin
      if (pop && (br_q != '1))   br_q   <= br_q + 1'b1;
      if (mis && (misc_q != '1)) misc_q <= misc_q + 1'b1;
    end
  end

  assign br_count  = br_q;
  assign mis_count = misc_q;
`endif

  assign pred_ready = !full;
  assign upd_valid  = upd_valid_q;
  assign upd_pc     = upd_pc_q;
  assign upd_taken  = upd_taken_q;
  assign mispredict = mis_q;
  assign res_err    = err_q;

endmodule
